// File: rtl/quantum_timer_bank.sv
// Multi-channel preemption timer: each channel counts to its own quantum and
// latches an interrupt request that is held until acknowledged.
module quantum_timer_bank #(
    parameter int N_CH            = 4,
    parameter int WIDTH           = 8,
    parameter int DEFAULT_QUANTUM = 5,
    parameter int CH_W            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_quantum,
    input  logic [N_CH-1:0]   start,
    input  logic [N_CH-1:0]   stop,
    input  logic              ack,
    output logic              irq,
    output logic [CH_W-1:0]   irq_ch,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   running,
    output logic [N_CH-1:0]   overrun
);

    logic [WIDTH-1:0] count_q   [N_CH];
    logic [WIDTH-1:0] quantum_q [N_CH];
    logic [N_CH-1:0]  running_q;
    logic [N_CH-1:0]  pending_q;
    logic [N_CH-1:0]  overrun_q;

    logic [N_CH-1:0]  cfg_hit;
    logic [N_CH-1:0]  ack_hit;
    logic [N_CH-1:0]  advance;
    logic [N_CH-1:0]  fire;

    assign irq     = |pending_q;
    assign pending = pending_q;
    assign running = running_q;
    assign overrun = overrun_q;

    // Scan from the top down so the lowest pending index is the last one written.
    always_comb begin
        // NOTE: default first so no path leaves irq_ch unassigned (no latch).
        irq_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) irq_ch = CH_W'(i);
        end
    end

    // stop gates the count in the edge it is sampled, so the value seen then is held.
    always_comb begin
        cfg_hit = '0;
        ack_hit = '0;
        advance = '0;
        fire    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
            ack_hit[i] = ack && irq && (irq_ch == CH_W'(i));
            advance[i] = running_q[i] && !stop[i] && (quantum_q[i] != '0);
            fire[i]    = advance[i] && (count_q[i] == quantum_q[i]) && !cfg_hit[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: these per-channel arrays are plain flops, not RAM, so resetting them is cheap and required.
            for (int i = 0; i < N_CH; i++) begin
                count_q[i]   <= '0;
                quantum_q[i] <= WIDTH'(DEFAULT_QUANTUM);
            end
            running_q <= '1;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_hit[i]) begin
                    // NOTE: non-blocking throughout so every channel sees pre-edge state.
                    quantum_q[i] <= cfg_quantum;
                    count_q[i]   <= '0;
                end else if (advance[i]) begin
                    count_q[i] <= (count_q[i] == quantum_q[i]) ? '0 : count_q[i] + WIDTH'(1);
                end
            end
            running_q <= (running_q | start) & ~stop;
            pending_q <= (pending_q & ~ack_hit) | fire;
            overrun_q <= overrun_q | (fire & pending_q & ~ack_hit);
        end
    end

endmodule

// File: tb/tb_quantum_timer_bank.sv
// Directed bench for quantum_timer_bank: edge-accurate expiry, ack, pause,
// reprogramming and overrun scenarios with hand-computed expectations.
module tb_quantum_timer_bank;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int CH_W  = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [WIDTH-1:0] cfg_quantum = '0;
    logic [N_CH-1:0]  start = '0;
    logic [N_CH-1:0]  stop = '0;
    logic             ack = 1'b0;
    logic             irq;
    logic [CH_W-1:0]  irq_ch;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  running;
    logic [N_CH-1:0]  overrun;

    int errors = 0;
    int checks = 0;

    quantum_timer_bank #(
        .N_CH(N_CH), .WIDTH(WIDTH), .DEFAULT_QUANTUM(5), .CH_W(CH_W)
    ) dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_quantum(cfg_quantum), .start(start), .stop(stop), .ack(ack),
        .irq(irq), .irq_ch(irq_ch), .pending(pending), .running(running),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Advance n rising edges; inputs change and outputs are sampled 1 ns after an edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reset edge is E0; on return the bench sits just after E0.
    task automatic do_reset();
        reset = 1'b1; cfg_we = 1'b0; start = '0; stop = '0; ack = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        checks++; if (running !== 4'b1111) begin errors++; $display("FAIL reset_running got=%b exp=1111", running); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun got=%b exp=0000", overrun); end
        checks++; if (irq !== 1'b0 || irq_ch !== 2'd0) begin errors++; $display("FAIL reset_irq got=%b/%0d exp=0/0", irq, irq_ch); end
    endtask

    task automatic test_default_period();
        tick(5);  // E5
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL e5_pending got=%b exp=0000", pending); end
        tick();   // E6
        checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL e6_pending got=%b exp=1111", pending); end
        checks++; if (irq !== 1'b1 || irq_ch !== 2'd0) begin errors++; $display("FAIL e6_irq got=%b/%0d exp=1/0", irq, irq_ch); end
        ack = 1'b1;
        tick();   // E7
        checks++; if (pending !== 4'b1110 || irq_ch !== 2'd1) begin errors++; $display("FAIL ack0 got=%b/%0d exp=1110/1", pending, irq_ch); end
        tick();   // E8
        checks++; if (pending !== 4'b1100 || irq_ch !== 2'd2) begin errors++; $display("FAIL ack1 got=%b/%0d exp=1100/2", pending, irq_ch); end
        tick();   // E9
        checks++; if (pending !== 4'b1000 || irq_ch !== 2'd3) begin errors++; $display("FAIL ack2 got=%b/%0d exp=1000/3", pending, irq_ch); end
        tick();   // E10
        ack = 1'b0;
        checks++; if (pending !== 4'b0000 || irq !== 1'b0 || irq_ch !== 2'd0) begin errors++; $display("FAIL ack3 got=%b/%b/%0d exp=0000/0/0", pending, irq, irq_ch); end
        tick(2);  // E12
        checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL e12_pending got=%b exp=1111", pending); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL e12_overrun got=%b exp=0000", overrun); end
    endtask

    // Ack 0 and 1 only; channels 2 and 3 stay pending into the E18 expiry.
    task automatic test_overrun();
        ack = 1'b1;
        tick(2);  // E14
        ack = 1'b0;
        checks++; if (pending !== 4'b1100) begin errors++; $display("FAIL ovr_pending got=%b exp=1100", pending); end
        tick(3);  // E17
        checks++; if (overrun !== 4'b0000 || irq_ch !== 2'd2) begin errors++; $display("FAIL ovr_e17 got=%b/%0d exp=0000/2", overrun, irq_ch); end
        tick();   // E18
        checks++; if (overrun !== 4'b1100) begin errors++; $display("FAIL ovr_e18 got=%b exp=1100", overrun); end
        checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL ovr_e18_pending got=%b exp=1111", pending); end
    endtask

    task automatic test_pause_resume();
        do_reset();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_quantum = 8'd3;
        tick();   // E1: ch1 count=0, Q=3
        cfg_we = 1'b0;
        tick(2);  // E3: count=2
        stop = 4'b0010;
        tick();   // E4: frozen at 2
        stop = 4'b0000;
        checks++; if (running !== 4'b1101) begin errors++; $display("FAIL pause_running got=%b exp=1101", running); end
        tick(5);  // E9
        start = 4'b0010; stop = 4'b0010;
        tick();   // E10
        start = 4'b0000; stop = 4'b0000;
        checks++; if (running[1] !== 1'b0) begin errors++; $display("FAIL start_stop_same got=%b exp=0", running[1]); end
        tick(4);  // E14
        checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL paused_expiry got=%b exp=0", pending[1]); end
        start = 4'b0010;
        tick();   // E15: running again, count still 2
        start = 4'b0000;
        checks++; if (running !== 4'b1111 || pending[1] !== 1'b0) begin errors++; $display("FAIL resume_e15 got=%b/%b exp=1111/0", running, pending[1]); end
        tick();   // E16: count=3
        checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL resume_e16 got=%b exp=0", pending[1]); end
        tick();   // E17: expire
        checks++; if (pending[1] !== 1'b1 || overrun[1] !== 1'b0) begin errors++; $display("FAIL resume_e17 got=%b/%b exp=1/0", pending[1], overrun[1]); end
    endtask

    task automatic test_reprogram_at_expiry();
        do_reset();
        tick(5);  // E5
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_quantum = 8'd0;
        tick();   // E6: ch3 write collides with its expiry
        cfg_we = 1'b0;
        checks++; if (pending !== 4'b0111) begin errors++; $display("FAIL reprog_e6 got=%b exp=0111", pending); end
        tick(14); // E20
        checks++; if (pending[3] !== 1'b0 || running[3] !== 1'b1) begin errors++; $display("FAIL q0_silent got=%b/%b exp=0/1", pending[3], running[3]); end
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_quantum = 8'd2;
        tick();   // E21
        cfg_we = 1'b0;
        tick(2);  // E23
        checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL q2_e23 got=%b exp=0", pending[3]); end
        tick();   // E24
        checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL q2_e24 got=%b exp=1", pending[3]); end
        tick(2);  // E26
        checks++; if (overrun[3] !== 1'b0) begin errors++; $display("FAIL q2_e26 got=%b exp=0", overrun[3]); end
        tick();   // E27: second expiry while pending
        checks++; if (overrun[3] !== 1'b1) begin errors++; $display("FAIL q2_e27 got=%b exp=1", overrun[3]); end
    endtask

    task automatic test_ack_collision();
        do_reset();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_quantum = 8'd1;
        tick();   // E1
        cfg_we = 1'b0;
        tick(2);  // E3: first expiry
        checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL coll_e3 got=%b exp=1", pending[0]); end
        tick();   // E4
        ack = 1'b1;
        tick();   // E5: ack and expiry together
        ack = 1'b0;
        checks++; if (pending[0] !== 1'b1 || overrun[0] !== 1'b0) begin errors++; $display("FAIL coll_e5 got=%b/%b exp=1/0", pending[0], overrun[0]); end
        ack = 1'b1;
        tick();   // E6: plain ack
        ack = 1'b0;
        checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL coll_e6 got=%b exp=0", pending[0]); end
    endtask

    // Continues from the collision scenario: ch1..3 pending since E6.
    task automatic test_reset_mid();
        stop = 4'b0100;
        tick();   // E7
        stop = 4'b0000;
        tick(6);  // E13
        checks++; if (running !== 4'b1011 || overrun[3] !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b/%b exp=1011/1", running, overrun[3]); end
        reset = 1'b1; stop = 4'b1111; ack = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_quantum = 8'd9;
        tick();   // E0'
        reset = 1'b0; stop = 4'b0000; ack = 1'b0; cfg_we = 1'b0;
        checks++; if (pending !== 4'b0000 || overrun !== 4'b0000) begin errors++; $display("FAIL mid_flags got=%b/%b exp=0000/0000", pending, overrun); end
        checks++; if (running !== 4'b1111 || irq !== 1'b0 || irq_ch !== 2'd0) begin errors++; $display("FAIL mid_outs got=%b/%b/%0d exp=1111/0/0", running, irq, irq_ch); end
        tick(5);
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL mid_e5 got=%b exp=0000", pending); end
        tick();
        checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL mid_e6 got=%b exp=1111", pending); end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_overrun();
        test_pause_resume();
        test_reprogram_at_expiry();
        test_ack_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
